// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 word-addressed memory slave with independent write/read FSMs.
// Define AXI_SLAVE_WLAST_CHECK_EN to check the write beat count against AWLEN.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);
  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next;
  logic [7:0]            w_len_q, w_len_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_in_range, w_last_bad, mem_we;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
  logic [8:0]            w_cnt_q, w_cnt_d;
`endif

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_err_q, r_err_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] bytes, span, lower, nxt;
    bytes = ADDR_WIDTH'(1) << size;
    span  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes;
    lower = a & ~(span - ADDR_WIDTH'(1));
    nxt   = a + bytes;
    return burst == 2'b00 ? a : (burst == 2'b10 && nxt == lower + span) ? lower : nxt;
  endfunction

  function automatic logic bad(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return size > 3'd2 || burst == 2'b11 ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  assign AWREADY = reset_n && w_state_q == W_IDLE;
  assign WREADY  = w_state_q == W_DATA;
  assign BVALID  = w_state_q == W_RESP;
  assign BRESP   = bresp_q;
  assign ARREADY = reset_n && r_state_q == R_IDLE;
  assign RVALID  = r_state_q == R_DATA;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign w_next  = step(w_addr_q, w_len_q, w_size_q, w_burst_q);
  assign r_next  = step(r_addr_q, r_len_q, r_size_q, r_burst_q);

  // Write FSM next state: latch AW, accept beats until WLAST, hold B until BREADY
  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_size_d   = w_size_q;
    w_burst_d  = w_burst_q;
    w_err_d    = w_err_q;
    bresp_d    = bresp_q;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
    w_cnt_d    = w_cnt_q;
    w_in_range = w_cnt_q <= {1'b0, w_len_q};
    w_last_bad = w_cnt_q != {1'b0, w_len_q};
`else
    w_in_range = 1'b1;
    w_last_bad = 1'b0;
`endif
    mem_we     = w_state_q == W_DATA && WVALID && !w_err_q && w_in_range;
    if (w_state_q == W_IDLE) begin
      if (AWVALID) begin
        w_addr_d  = AWADDR;
        w_len_d   = AWLEN;
        w_size_d  = AWSIZE;
        w_burst_d = AWBURST;
        w_err_d   = bad(AWLEN, AWSIZE, AWBURST);
`ifdef AXI_SLAVE_WLAST_CHECK_EN
        w_cnt_d   = 9'd0;
`endif
        w_state_d = W_DATA;
      end
    end else if (w_state_q == W_DATA) begin
      if (WVALID) begin
        w_addr_d = w_next;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
        w_cnt_d  = &w_cnt_q ? w_cnt_q : w_cnt_q + 9'd1;
        if (!w_in_range) w_err_d = 1'b1;
`endif
        if (WLAST) begin
          bresp_d   = (w_err_q || w_last_bad) ? 2'b10 : 2'b00;
          w_state_d = W_RESP;
        end
      end
    end else if (BREADY) begin
      bresp_d   = 2'b00;
      w_state_d = W_IDLE;
    end
  end

  // Write FSM registers; reset abandons any burst in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      bresp_q   <= 2'b00;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
      w_cnt_q   <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      bresp_q   <= bresp_d;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
      w_cnt_q   <= w_cnt_d;
`endif
    end
  end

  // Storage is never reset; a read at the same edge sees the old word
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_addr_q[IW+1:2]] <= WDATA;
  end

  // Read FSM next state: prefetch each beat so R runs back-to-back
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    if (r_state_q == R_IDLE) begin
      if (ARVALID) begin
        r_addr_d  = ARADDR;
        r_len_d   = ARLEN;
        r_size_d  = ARSIZE;
        r_burst_d = ARBURST;
        r_err_d   = bad(ARLEN, ARSIZE, ARBURST);
        rdata_d   = r_err_d ? '0 : mem[ARADDR[IW+1:2]];
        rresp_d   = r_err_d ? 2'b10 : 2'b00;
        rlast_d   = ARLEN == 8'd0;
        r_cnt_d   = ARLEN;
        r_state_d = R_DATA;
      end
    end else if (RREADY) begin
      if (rlast_q) begin
        rlast_d   = 1'b0;
        r_state_d = R_IDLE;
      end else begin
        r_addr_d = r_next;
        rdata_d  = r_err_q ? '0 : mem[r_next[IW+1:2]];
        r_cnt_d  = r_cnt_q - 8'd1;
        rlast_d  = r_cnt_q == 8'd1;
      end
    end
  end

  // Read FSM registers; reset drops RVALID immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end
endmodule
